// File: rtl/led_panel_ctrl.sv
// LED panel controller: stage LEDs, RGB cycle, indicator LEDs and digit codes driven from machine state.
// Optional macro LED_CHASE_EN enables a one-hot chase on the stage LEDs in the finish state.
module led_panel_ctrl #(
  parameter int N_STAGES = 8,
  parameter int TICK_DIV = 25000000,
  parameter int CODE_W   = 6
) (
  input  logic                        cp,
  input  logic                        clr_n,
  input  logic [2:0]                  state,
  input  logic [N_STAGES-1:0]         stage_en,
  input  logic [$clog2(N_STAGES)-1:0] active_stage,
  input  logic                        power_on,
  input  logic                        set_on,
  input  logic [CODE_W-1:0]           in_left,
  input  logic [CODE_W-1:0]           in_mid,
  input  logic [CODE_W-1:0]           in_right,
  output logic [CODE_W-1:0]           code_left,
  output logic [CODE_W-1:0]           code_mid,
  output logic [CODE_W-1:0]           code_right,
  output logic [N_STAGES-1:0]         stage_led,
  output logic                        set_led,
  output logic                        power_led,
  output logic [2:0]                  color_led,
  output logic                        blink
);

  localparam int AW    = $clog2(N_STAGES);
  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0]  CNT_MAX    = CNT_W'(TICK_DIV - 1);
  localparam logic [CODE_W-1:0] CODE_OFF   = CODE_W'(55);
  localparam logic [CODE_W-1:0] CODE_DONE  = CODE_W'(56);
  localparam logic [CODE_W-1:0] CODE_PAUSE = CODE_W'(57);
  localparam logic [CODE_W-1:0] CODE_ERR   = CODE_W'(58);
  localparam logic [CODE_W-1:0] CODE_B0    = CODE_W'(59);
  localparam logic [CODE_W-1:0] CODE_B1    = CODE_W'(60);
  localparam logic [CODE_W-1:0] CODE_B2    = CODE_W'(61);

  typedef enum logic [2:0] {
    ST_SHUT  = 3'd0,
    ST_BEGIN = 3'd1,
    ST_SET   = 3'd2,
    ST_RUN   = 3'd3,
    ST_ERR   = 3'd4,
    ST_PAUSE = 3'd5,
    ST_FIN   = 3'd6
  } panelState_e;

  panelState_e         curState, prevState;
  logic                stateChg, tick, inRange;
  logic [CNT_W-1:0]    tickCnt, cntNext;
  logic                blinkNext;
  logic [2:0]          colorNext;
  logic [N_STAGES-1:0] stageMask, stageNext;
  logic [CODE_W-1:0]   leftNext, midNext, rightNext;
  logic                setNext;
`ifdef LED_CHASE_EN
  logic [AW-1:0]       chasePos, chaseNext;
`endif

  // Code 7 is an undefined machine state and is folded onto shutdown.
  assign curState = (state == 3'd7) ? ST_SHUT : panelState_e'(state);
  assign stateChg = (curState != prevState);
  assign inRange  = ({1'b0, active_stage} < (AW + 1)'(N_STAGES));
  assign stageMask = inRange ? (N_STAGES'(1) << active_stage) : '0;

  always_comb begin
    cntNext   = tickCnt;
    blinkNext = blink;
    tick      = 1'b0;
    // A state change restarts the blink phase and swallows a coincident tick.
    if (curState == ST_SHUT) begin
      cntNext   = '0;
      blinkNext = 1'b0;
    end else if (stateChg) begin
      cntNext   = '0;
      blinkNext = 1'b1;
    end else if (tickCnt == CNT_MAX) begin
      cntNext   = '0;
      blinkNext = ~blink;
      tick      = 1'b1;
    end else begin
      cntNext = tickCnt + 1'b1;
    end
  end

`ifdef LED_CHASE_EN
  always_comb begin
    chaseNext = '0;
    if (curState == ST_FIN) begin
      if (stateChg)
        chaseNext = '0;
      else if (tick)
        chaseNext = (chasePos == AW'(N_STAGES - 1)) ? '0 : chasePos + 1'b1;
      else
        chaseNext = chasePos;
    end
  end
`endif

  // Outputs are built from blinkNext so registered LEDs stay in phase with blink.
  always_comb begin
    stageNext = '0;
    colorNext = '0;
    leftNext  = in_left;
    midNext   = in_mid;
    rightNext = in_right;
    setNext   = set_on;
    case (curState)
      ST_BEGIN: begin
        stageNext = '1;
        leftNext  = CODE_B0;
        midNext   = CODE_B1;
        rightNext = CODE_B2;
        setNext   = 1'b1;
      end
      ST_SET: stageNext = stage_en;
      ST_RUN: begin
        stageNext = (stage_en & ~stageMask) | (stageMask & {N_STAGES{blinkNext}});
        colorNext = tick ? color_led + 3'd1 : color_led;
      end
      ST_ERR: begin
        stageNext = stage_en & {N_STAGES{blinkNext}};
        midNext   = CODE_ERR;
      end
      ST_PAUSE: begin
        stageNext = stage_en | stageMask;
        colorNext = color_led;
        midNext   = blinkNext ? CODE_PAUSE : in_mid;
      end
      ST_FIN: begin
`ifdef LED_CHASE_EN
        stageNext = N_STAGES'(1) << chaseNext;
`else
        stageNext = '1;
`endif
        leftNext  = CODE_DONE;
        midNext   = CODE_DONE;
        rightNext = CODE_DONE;
        setNext   = 1'b1;
      end
      default: begin
        leftNext  = CODE_OFF;
        midNext   = CODE_OFF;
        rightNext = CODE_OFF;
        setNext   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge cp or negedge clr_n) begin
    if (!clr_n) begin
      prevState  <= ST_SHUT;
      tickCnt    <= '0;
      blink      <= 1'b0;
      color_led  <= '0;
      stage_led  <= '0;
      set_led    <= 1'b0;
      power_led  <= 1'b0;
      code_left  <= CODE_OFF;
      code_mid   <= CODE_OFF;
      code_right <= CODE_OFF;
    end else begin
      prevState  <= curState;
      tickCnt    <= cntNext;
      blink      <= blinkNext;
      color_led  <= colorNext;
      stage_led  <= stageNext;
      set_led    <= setNext;
      power_led  <= power_on;
      code_left  <= leftNext;
      code_mid   <= midNext;
      code_right <= rightNext;
    end
  end

`ifdef LED_CHASE_EN
  always_ff @(posedge cp or negedge clr_n) begin
    if (!clr_n) chasePos <= '0;
    else        chasePos <= chaseNext;
  end
`endif

endmodule

// File: tb/tb_led_panel_ctrl.sv
// Directed bench for led_panel_ctrl (N_STAGES=8 and 12, TICK_DIV=4); honours LED_CHASE_EN like the design.
module tb_led_panel_ctrl;

  logic        cp = 1'b0;
  logic        clr_n = 1'b1;
  logic [2:0]  state = 3'd0;
  logic [7:0]  stageEn = 8'h0F;
  logic [2:0]  activeStage = 3'd2;
  logic        powerOn = 1'b1;
  logic        setOn = 1'b0;
  logic [5:0]  inLeft = 6'd10, inMid = 6'd20, inRight = 6'd30;
  logic [5:0]  codeLeft, codeMid, codeRight;
  logic [7:0]  stageLed;
  logic        setLed, powerLed, blink;
  logic [2:0]  colorLed;

  logic [2:0]  state12 = 3'd0;
  logic [11:0] stageEn12 = 12'h000;
  logic [3:0]  active12 = 4'd0;
  logic [5:0]  codeLeft12, codeMid12, codeRight12;
  logic [11:0] stageLed12;
  logic        setLed12, powerLed12, blink12;
  logic [2:0]  colorLed12;

  int total = 0;
  int bad = 0;

  always #5 cp = ~cp;

  led_panel_ctrl #(.N_STAGES(8), .TICK_DIV(4), .CODE_W(6)) dut (
    .cp(cp), .clr_n(clr_n), .state(state), .stage_en(stageEn), .active_stage(activeStage),
    .power_on(powerOn), .set_on(setOn), .in_left(inLeft), .in_mid(inMid), .in_right(inRight),
    .code_left(codeLeft), .code_mid(codeMid), .code_right(codeRight), .stage_led(stageLed),
    .set_led(setLed), .power_led(powerLed), .color_led(colorLed), .blink(blink)
  );

  led_panel_ctrl #(.N_STAGES(12), .TICK_DIV(4), .CODE_W(6)) dut12 (
    .cp(cp), .clr_n(clr_n), .state(state12), .stage_en(stageEn12), .active_stage(active12),
    .power_on(powerOn), .set_on(setOn), .in_left(inLeft), .in_mid(inMid), .in_right(inRight),
    .code_left(codeLeft12), .code_mid(codeMid12), .code_right(codeRight12), .stage_led(stageLed12),
    .set_led(setLed12), .power_led(powerLed12), .color_led(colorLed12), .blink(blink12)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge cp);
    #1;
  endtask

  task automatic chkCodes(input string tag, input int l, input int m, input int r);
    chk({tag, "_left"},  32'(codeLeft),  32'(l));
    chk({tag, "_mid"},   32'(codeMid),   32'(m));
    chk({tag, "_right"}, 32'(codeRight), 32'(r));
  endtask

  initial begin
    logic [7:0] expStage;
    // Asynchronous reset before any clock edge
    #2 clr_n = 1'b0;
    #1;
    chk("rst_stage", 32'(stageLed), 32'h00);
    chk("rst_color", 32'(colorLed), 32'h0);
    chk("rst_blink", 32'(blink), 32'h0);
    chk("rst_set", 32'(setLed), 32'h0);
    chk("rst_power", 32'(powerLed), 32'h0);
    chkCodes("rst", 55, 55, 55);
    step(2);
    chk("rst_hold_stage", 32'(stageLed), 32'h00);
    #3 clr_n = 1'b1;

    // Shutdown after reset release
    step(1);
    chk("shut_stage", 32'(stageLed), 32'h00);
    chk("shut_blink", 32'(blink), 32'h0);
    chk("shut_power", 32'(powerLed), 32'h1);
    chkCodes("shut", 55, 55, 55);
    step(5);
    chk("shut_blink_hold", 32'(blink), 32'h0);

    // Run: bit 2 blinks, colour advances per tick
    state = 3'd3;
    step(1);
    chk("run0_blink", 32'(blink), 32'h1);
    chk("run0_stage", 32'(stageLed), 32'h0F);
    chk("run0_color", 32'(colorLed), 32'h0);
    chk("run0_set", 32'(setLed), 32'h0);
    chkCodes("run0", 10, 20, 30);
    for (int k = 1; k <= 11; k++) begin
      step(4);
      chk($sformatf("run%0d_color", k), 32'(colorLed), 32'(k % 8));
      chk($sformatf("run%0d_blink", k), 32'(blink), 32'((k % 2) == 0));
      expStage = ((k % 2) == 0) ? 8'h0F : 8'h0B;
      chk($sformatf("run%0d_stage", k), 32'(stageLed), 32'(expStage));
    end

    // Pause: colour held, active bit forced, mid code alternates
    state = 3'd5;
    stageEn = 8'h0B;
    step(1);
    chk("pause0_blink", 32'(blink), 32'h1);
    chk("pause0_color", 32'(colorLed), 32'h3);
    chk("pause0_stage", 32'(stageLed), 32'h0F);
    chkCodes("pause0", 10, 57, 30);
    step(4);
    chk("pause1_blink", 32'(blink), 32'h0);
    chk("pause1_color", 32'(colorLed), 32'h3);
    chk("pause1_stage", 32'(stageLed), 32'h0F);
    chk("pause1_mid", 32'(codeMid), 32'd20);
    step(4);
    chk("pause2_mid", 32'(codeMid), 32'd57);
    chk("pause2_color", 32'(colorLed), 32'h3);

    // Back to run: blink restarts at 1, colour resumes from 3
    state = 3'd3;
    stageEn = 8'h0F;
    step(1);
    chk("resume0_blink", 32'(blink), 32'h1);
    chk("resume0_color", 32'(colorLed), 32'h3);
    step(4);
    chk("resume1_color", 32'(colorLed), 32'h4);
    chk("resume1_stage", 32'(stageLed), 32'h0B);

    // State change on the wrap cycle: change wins over tick
    step(3);
    chk("pre_coll_blink", 32'(blink), 32'h0);
    state = 3'd4;
    stageEn = 8'hA5;
    step(1);
    chk("coll_blink", 32'(blink), 32'h1);
    chk("coll_color", 32'(colorLed), 32'h0);
    chk("coll_stage", 32'(stageLed), 32'hA5);
    chkCodes("err", 10, 58, 30);
    step(3);
    chk("err_hold_blink", 32'(blink), 32'h1);
    chk("err_hold_stage", 32'(stageLed), 32'hA5);
    step(1);
    chk("err_tog_blink", 32'(blink), 32'h0);
    chk("err_tog_stage", 32'(stageLed), 32'h00);
    chk("err_tog_mid", 32'(codeMid), 32'd58);

    // Finish
    state = 3'd6;
    step(1);
    chk("fin_set", 32'(setLed), 32'h1);
    chkCodes("fin", 56, 56, 56);
`ifdef LED_CHASE_EN
    chk("fin0_stage", 32'(stageLed), 32'h01);
`else
    chk("fin0_stage", 32'(stageLed), 32'hFF);
`endif
    for (int k = 1; k <= 8; k++) begin
      step(4);
`ifdef LED_CHASE_EN
      expStage = 8'h01 << (k % 8);
`else
      expStage = 8'hFF;
`endif
      chk($sformatf("fin%0d_stage", k), 32'(stageLed), 32'(expStage));
    end

    // State 7 acts as shutdown
    state = 3'd7;
    powerOn = 1'b0;
    step(1);
    chk("s7_stage", 32'(stageLed), 32'h00);
    chk("s7_blink", 32'(blink), 32'h0);
    chk("s7_set", 32'(setLed), 32'h0);
    chk("s7_power", 32'(powerLed), 32'h0);
    chk("s7_color", 32'(colorLed), 32'h0);
    chkCodes("s7", 55, 55, 55);
    step(5);
    chk("s7_blink_hold", 32'(blink), 32'h0);

    // Begin and set
    state = 3'd1;
    powerOn = 1'b1;
    step(1);
    chk("begin_stage", 32'(stageLed), 32'hFF);
    chk("begin_set", 32'(setLed), 32'h1);
    chk("begin_power", 32'(powerLed), 32'h1);
    chkCodes("begin", 59, 60, 61);
    state = 3'd2;
    setOn = 1'b1;
    stageEn = 8'h3C;
    step(1);
    chk("set_stage", 32'(stageLed), 32'h3C);
    chk("set_set1", 32'(setLed), 32'h1);
    chkCodes("set", 10, 20, 30);
    setOn = 1'b0;
    step(1);
    chk("set_set0", 32'(setLed), 32'h0);

    // Asynchronous reset in the middle of run
    state = 3'd3;
    stageEn = 8'h0F;
    step(1);
    step(8);
    chk("mid_pre_color", 32'(colorLed), 32'h2);
    #1 clr_n = 1'b0;
    #1;
    chk("mid_rst_color", 32'(colorLed), 32'h0);
    chk("mid_rst_stage", 32'(stageLed), 32'h00);
    chk("mid_rst_blink", 32'(blink), 32'h0);
    chkCodes("mid_rst", 55, 55, 55);
    #2 clr_n = 1'b1;
    step(1);
    chk("mid_rel_blink", 32'(blink), 32'h1);
    chk("mid_rel_color", 32'(colorLed), 32'h0);
    chk("mid_rel_stage", 32'(stageLed), 32'h0F);

    // N_STAGES=12: out-of-range active stage never blinks
    state12 = 3'd3;
    stageEn12 = 12'hABC;
    active12 = 4'd13;
    step(1);
    chk("oor0_blink", 32'(blink12), 32'h1);
    chk("oor0_stage", 32'(stageLed12), 32'hABC);
    step(4);
    chk("oor1_blink", 32'(blink12), 32'h0);
    chk("oor1_stage", 32'(stageLed12), 32'hABC);
    active12 = 4'd9;
    step(1);
    chk("inr_stage", 32'(stageLed12), 32'h8BC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
